bitop_eval_arbiter: RTL and testbench

//   Shares one bit-operation evaluator datapath between NREQ requesters.
//   The evaluator is 2 XOR lanes + 4 NOT lanes over a 20-bit vector, producing a 10-bit result.

---
 rtl/bitop_eval_arbiter.sv | 104 ++++++++++
 tb/tb_bitop_eval_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bitop_eval_arbiter.sv
// Round-robin arbiter sharing one XOR/NOT bit evaluator between NREQ requesters.
// The result is registered once, tagged with the requester id, and retired through a valid/ready handshake.
module bitop_eval_arbiter #(
  parameter int NREQ  = 2,
  parameter int DW    = 20,
  parameter int RW    = 10,
  parameter int IDW   = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RW-1:0]     res_data,
  output logic [IDW-1:0]    res_id,
  output logic [CNT_W-1:0]  done_cnt
);

  logic              r_res_valid;
  logic [RW-1:0]     r_res_data;
  logic [IDW-1:0]    r_res_id;
  logic [CNT_W-1:0]  r_done_cnt;
  logic [IDW-1:0]    r_rr_ptr;

  logic              w_load_en;
  logic              w_gnt_found;
  logic [IDW-1:0]    w_gnt_idx;
  logic [DW-1:0]     w_gnt_data;
  logic [NREQ-1:0]   w_req_ready;
  logic [IDW-1:0]    w_ptr_next;

  function automatic logic [RW-1:0] eval_f(input logic [DW-1:0] d);
    logic [RW-1:0] r;
    r    = '0;
    r[0] = d[1] ^ d[3];
    r[1] = d[2] ^ d[4];
    r[2] = ~d[5];
    r[3] = ~d[6];
    r[4] = ~d[7];
    r[5] = ~d[8];
    return r;
  endfunction

  assign w_load_en = !r_res_valid || res_ready;

  // Winner is the valid requester with the smallest rotation distance from r_rr_ptr.
  always_comb begin
    int v_best;
    int v_dist;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_gnt_data  = '0;
    w_req_ready = '0;
    v_best      = NREQ;
    v_dist      = 0;
    for (int i = 0; i < NREQ; i++) begin
      v_dist = (i + NREQ - int'(r_rr_ptr)) % NREQ;
      if (req_valid[i] && (v_dist < v_best)) begin
        v_best      = v_dist;
        w_gnt_found = 1'b1;
        w_gnt_idx   = IDW'(i);
        w_gnt_data  = req_data[i*DW +: DW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      w_req_ready[i] = rst_n && w_load_en && w_gnt_found && (w_gnt_idx == IDW'(i));
    end
  end

  assign w_ptr_next = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_done_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (r_res_valid && res_ready) begin
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
      // A drain and a new load may happen on the same edge, so the load wins over clearing valid.
      if (w_load_en && w_gnt_found) begin
        r_res_valid <= 1'b1;
        r_res_data  <= eval_f(w_gnt_data);
        r_res_id    <= w_gnt_idx;
        r_rr_ptr    <= w_ptr_next;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_bitop_eval_arbiter.sv
// Bench for bitop_eval_arbiter: directed scenarios plus random traffic, checked every
// cycle against a behavioural model of the arbitration and evaluator rules.
module tb_bitop_eval_arbiter;
  localparam int NREQ  = 2;
  localparam int DW    = 20;
  localparam int RW    = 10;
  localparam int IDW   = 2;
  localparam int CNT_W = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [RW-1:0]        res_data;
  logic [IDW-1:0]       res_id;
  logic [CNT_W-1:0]     done_cnt;

  bitop_eval_arbiter #(
    .NREQ(NREQ), .DW(DW), .RW(RW), .IDW(IDW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Evaluator written straight from the bit rules: low two bits XOR pairs, next four inverted bits.
  function automatic logic [RW-1:0] model_f(input logic [DW-1:0] d);
    return {4'b0000, ~d[8], ~d[7], ~d[6], ~d[5], d[2] ^ d[4], d[1] ^ d[3]};
  endfunction

  bit              m_valid;
  logic [RW-1:0]   m_data;
  int              m_id;
  int              m_cnt;
  int              m_ptr;

  initial begin
    int g;
    int idx;
    bit load;
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0]   d;
    m_valid = 0; m_data = '0; m_id = 0; m_cnt = 0; m_ptr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_id",    32'(res_id),    32'd0);
        check("rst_done_cnt",  32'(done_cnt),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        m_valid = 0; m_data = '0; m_id = 0; m_cnt = 0; m_ptr = 0;
      end else begin
        g = -1;
        load = !m_valid || res_ready;
        if (load) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && (((int'(req_valid) >> idx) & 1) == 1)) g = idx;
          end
        end
        exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("res_valid", 32'(res_valid), 32'(m_valid));
        check("res_data",  32'(res_data),  32'(m_data));
        check("res_id",    32'(res_id),    32'(m_id));
        check("done_cnt",  32'(done_cnt),  32'(m_cnt));
        if (m_valid && res_ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (g >= 0) begin
          d       = DW'(req_data >> (g * DW));
          m_valid = 1;
          m_data  = model_f(d);
          m_id    = g;
          m_ptr   = (g + 1) % NREQ;
        end else if (m_valid && res_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    req_data = (NREQ*DW)'({$urandom(), $urandom()});
  endtask

  initial begin
    logic [RW-1:0]  held;
    logic [IDW-1:0] held_id;
    logic [IDW-1:0] prev;
    rst_n = 1'b0; res_ready = 1'b0; req_valid = '0; req_data = '0;
    repeat (3) begin
      req_valid = NREQ'($urandom()); res_ready = 1'($urandom()); rand_data();
      #1;
      check("lit_rst_ready", 32'(req_ready), 32'd0);
      check("lit_rst_valid", 32'(res_valid), 32'd0);
      step();
    end

    rst_n = 1'b1; req_valid = '0; res_ready = 1'b1;
    step();
    req_valid = 2'b01; req_data = '0; req_data[DW-1:0] = 20'h0001A;
    step();
    check("lit_first_valid", 32'(res_valid), 32'd1);
    check("lit_first_data",  32'(res_data),  32'h03E);
    check("lit_first_id",    32'(res_id),    32'd0);
    req_valid = '0;
    step();
    check("lit_first_cnt",   32'(done_cnt),  32'd1);

    req_valid = 2'b11; rand_data();
    step();
    prev = res_id;
    repeat (5) begin
      rand_data();
      step();
      check("lit_alt_valid", 32'(res_valid), 32'd1);
      check("lit_alt_id",    32'(res_id),    32'((int'(prev) + 1) % NREQ));
      prev = res_id;
    end

    res_ready = 1'b0; held = res_data; held_id = res_id;
    repeat (3) begin
      rand_data();
      #1;
      check("lit_bp_ready", 32'(req_ready), 32'd0);
      step();
      check("lit_bp_data",  32'(res_data),  32'(held));
    end
    res_ready = 1'b1;
    #1;
    check("lit_bp_resume", 32'(req_ready), 32'(1 << ((int'(held_id) + 1) % NREQ)));
    step();
    check("lit_pre_rst_valid", 32'(res_valid), 32'd1);

    rst_n = 1'b0;
    #1;
    check("lit_async_valid", 32'(res_valid), 32'd0);
    check("lit_async_data",  32'(res_data),  32'd0);
    check("lit_async_cnt",   32'(done_cnt),  32'd0);
    check("lit_async_ready", 32'(req_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1; req_valid = 2'b11;
    #1;
    check("lit_post_rst_ready", 32'(req_ready), 32'd1);
    step();
    check("lit_post_rst_id", 32'(res_id), 32'd0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1; res_ready = 1'b1; req_valid = 2'b01;
    repeat (17) begin
      rand_data();
      step();
    end
    req_valid = '0;
    step();
    check("lit_wrap_cnt",   32'(done_cnt),  32'd1);
    check("lit_wrap_valid", 32'(res_valid), 32'd0);

    repeat (400) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      req_valid = NREQ'($urandom());
      res_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end
    rst_n = 1'b1; req_valid = '0; res_ready = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
